// File: rtl/pwm_burst_pkg.sv
// rtl/pwm_burst_pkg.sv - shared types and register map constants for pwm_burst
// Purpose: FSM state encoding, register offsets, CTRL bit positions and
//          parameter defaults used by pwm_burst and its edge detector.
// Ports:   none (package).
package pwm_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int         CNT_W_DEF     = 32;
  localparam logic [7:0] ADDR_BASE_DEF = 8'h50;
  localparam logic [7:0] REG_WINDOW    = 8'd10;

  localparam logic [7:0] OFF_CTRL   = 8'd0;
  localparam logic [7:0] OFF_STATUS = 8'd1;
  localparam logic [7:0] OFF_LEN0   = 8'd2;
  localparam logic [7:0] OFF_LEN3   = 8'd5;
  localparam logic [7:0] OFF_SENT0  = 8'd6;
  localparam logic [7:0] OFF_SENT3  = 8'd9;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CONT  = 2;

endpackage

// File: rtl/pwm_burst_edge.sv
// rtl/pwm_burst_edge.sv - one-cycle delay register with rise/fall strobes
// Purpose: registers i_d once and derives single-cycle edge strobes from
//          the current input against its delayed copy.
// Ports:   clk, res_n  - clock, async active-low reset
//          i_d         - input level (same clock domain)
//          o_q         - i_d delayed by one cycle
//          o_rise      - i_d & ~o_q
//          o_fall      - ~i_d & o_q
module pwm_burst_edge (
  input  logic clk,
  input  logic res_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q    = r_q;
  assign o_rise = i_d & ~r_q;
  assign o_fall = ~i_d & r_q;

endmodule

// File: rtl/pwm_burst.sv
// rtl/pwm_burst.sv - gates a PWM waveform into bursts of N whole pulses
// Purpose: forwards complete pwm_in pulses to pulse_out, either exactly LEN
//          of them per start event or continuously until aborted, with a
//          byte-wide register window for control, length and pulse count.
// Ports:   clk, res_n        - clock, async active-low reset
//          addr, data_in, we - register bus (one byte per cycle)
//          data_out          - registered read data
//          pwm_in            - source waveform
//          trig              - external start level (rising edge starts)
//          pulse_out         - gated waveform, one cycle behind pwm_in
//          busy, done        - status (done is sticky until next start)
module pwm_burst
  import pwm_burst_pkg::*;
#(
  parameter logic [7:0] ADDR_BASE = ADDR_BASE_DEF,
  parameter int         CNT_W     = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  input  logic       we,
  output logic [7:0] data_out,
  input  logic       pwm_in,
  input  logic       trig,
  output logic       pulse_out,
  output logic       busy,
  output logic       done
);

  state_t             r_state;
  logic [31:0]        r_len;
  logic [CNT_W-1:0]   r_len_q;
  logic [CNT_W-1:0]   r_sent;
  logic               r_cont;
  logic               r_gate;
  logic               r_ovf;
  logic               r_done;
  logic               r_busy;
  logic               r_pulse;
  logic [7:0]         r_data_out;

  logic               w_pwm_q, w_pwm_rise, w_pwm_fall;
  logic               w_trig_q, w_trig_rise, w_trig_fall;
  logic               w_unused;

  logic [7:0]         w_off;
  logic               w_in_win;
  logic               w_wr;
  logic               w_ctrl_wr;
  logic               w_start;
  logic               w_abort;
  logic               w_cont_nxt;
  logic [1:0]         w_byte_sel;
  logic               w_is_len;
  logic               w_is_sent;
  logic [31:0]        w_sent32;
  logic [7:0]         w_rd_byte;
  logic [CNT_W-1:0]   w_sent_inc;
  logic               w_gate_eff;

  pwm_burst_edge u_pwm_edge (
    .clk    (clk),
    .res_n  (res_n),
    .i_d    (pwm_in),
    .o_q    (w_pwm_q),
    .o_rise (w_pwm_rise),
    .o_fall (w_pwm_fall)
  );

  pwm_burst_edge u_trig_edge (
    .clk    (clk),
    .res_n  (res_n),
    .i_d    (trig),
    .o_q    (w_trig_q),
    .o_rise (w_trig_rise),
    .o_fall (w_trig_fall)
  );

  assign w_unused = &{1'b0, w_pwm_q, w_trig_q, w_trig_fall};

  // Register decode
  assign w_off      = addr - ADDR_BASE;
  assign w_in_win   = (addr >= ADDR_BASE) && (w_off < REG_WINDOW);
  assign w_wr       = we && w_in_win;
  assign w_ctrl_wr  = w_wr && (w_off == OFF_CTRL);
  assign w_abort    = w_ctrl_wr && data_in[CTRL_ABORT];
  assign w_start    = (w_ctrl_wr && data_in[CTRL_START]) || w_trig_rise;
  // A CTRL write carrying START|CONT must start in continuous mode.
  assign w_cont_nxt = w_ctrl_wr ? data_in[CTRL_CONT] : r_cont;

  // LEN (offsets 2..5) and SENT (6..9) share the same low-bit byte index.
  assign w_byte_sel = w_off[1:0] - 2'd2;
  assign w_is_len   = (w_off >= OFF_LEN0) && (w_off <= OFF_LEN3);
  assign w_is_sent  = (w_off >= OFF_SENT0) && (w_off <= OFF_SENT3);
  assign w_sent32   = 32'(r_sent);

  always_comb begin
    w_rd_byte = 8'h00;
    if (w_off == OFF_CTRL) begin
      w_rd_byte = {5'b0, r_cont, 2'b00};
    end else if (w_off == OFF_STATUS) begin
      w_rd_byte = {5'b0, r_ovf, r_done, r_busy};
    end else if (w_is_len) begin
      w_rd_byte = r_len[{w_byte_sel, 3'b000} +: 8];
    end else if (w_is_sent) begin
      w_rd_byte = w_sent32[{w_byte_sel, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_data_out <= 8'h00;
      r_len      <= 32'h0;
      r_cont     <= 1'b0;
    end else begin
      if (w_in_win) begin
        r_data_out <= w_rd_byte;
      end
      if (w_ctrl_wr) begin
        r_cont <= data_in[CTRL_CONT];
      end
      if (w_wr && w_is_len) begin
        r_len[{w_byte_sel, 3'b000} +: 8] <= data_in;
      end
    end
  end

  // Burst engine
  assign w_sent_inc = r_sent + {{(CNT_W-1){1'b0}}, 1'b1};

  // The gate decision is made on the rising edge so a pulse is either
  // forwarded whole or not at all; the fall always closes it.
  always_comb begin
    w_gate_eff = r_gate;
    if (w_pwm_rise) begin
      w_gate_eff = r_cont || (r_sent < r_len_q);
    end else if (w_pwm_fall) begin
      w_gate_eff = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= ST_IDLE;
      r_len_q <= '0;
      r_sent  <= '0;
      r_gate  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_pulse <= 1'b0;
    end else if (w_abort) begin
      r_state <= ST_IDLE;
      r_gate  <= 1'b0;
      r_busy  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_pulse <= 1'b0;
          if (w_start) begin
            r_len_q <= r_len[CNT_W-1:0];
            r_sent  <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_gate  <= 1'b0;
            if ((r_len[CNT_W-1:0] == '0) && !w_cont_nxt) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_ARM;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_ARM: begin
          // Never join a pulse already in progress.
          if (!pwm_in) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_pulse <= pwm_in & w_gate_eff;
          r_gate  <= w_gate_eff;
          if (w_pwm_fall && r_gate) begin
            if (&r_sent) begin
              r_ovf <= 1'b1;
            end else begin
              r_sent <= w_sent_inc;
              if (&w_sent_inc) begin
                r_ovf <= 1'b1;
              end
            end
            if (!r_cont && (w_sent_inc == r_len_q)) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_pulse <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_out  = r_data_out;
  assign pulse_out = r_pulse;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_pwm_burst.sv
// tb/tb_pwm_burst.sv - scoreboard bench for pwm_burst
module tb_pwm_burst;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data_in = 8'h00;
  logic       we = 1'b0;
  logic [7:0] data_out;
  logic       pwm_in = 1'b0;
  logic       trig = 1'b0;
  logic       pulse_out;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  pwm_burst #(.ADDR_BASE(8'h50), .CNT_W(32)) dut (
    .clk       (clk),
    .res_n     (res_n),
    .addr      (addr),
    .data_in   (data_in),
    .we        (we),
    .data_out  (data_out),
    .pwm_in    (pwm_in),
    .trig      (trig),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  int         exp_w_q[$];
  logic [7:0] rd_exp_q[$];
  string      rd_name_q[$];
  logic       rd_vld = 1'b0;
  int         pulses_seen = 0;
  time        last_rise = 0;
  int         cur_w = 0;
  logic       po_prev = 1'b0;
  logic       pwm_prev = 1'b0;

  // Monitor: pulse widths/latency and register read responses
  always @(negedge clk) begin
    int         e;
    logic [7:0] re;
    string      rn;
    if (pwm_in && !pwm_prev) last_rise = $time;
    if (pulse_out && !po_prev) begin
      n_checks++;
      if ($time - last_rise != 10) begin
        n_errors++;
        $display("FAIL latency: got %0t required 10", $time - last_rise);
      end
      cur_w = 1;
    end else if (pulse_out) begin
      cur_w++;
    end
    if (!pulse_out && po_prev) begin
      pulses_seen++;
      n_checks++;
      if (exp_w_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_pulse: got width %0d required no pulse", cur_w);
      end else begin
        e = exp_w_q.pop_front();
        if (cur_w != e) begin
          n_errors++;
          $display("FAIL pulse_width: got %0d required %0d", cur_w, e);
        end
      end
    end
    if (rd_vld) begin
      re = rd_exp_q.pop_front();
      rn = rd_name_q.pop_front();
      n_checks++;
      if (data_out !== re) begin
        n_errors++;
        $display("FAIL %s: got %02h required %02h", rn, data_out, re);
      end
    end
    po_prev  = pulse_out;
    pwm_prev = pwm_in;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; data_in = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e, input string nm);
    addr = a;
    tick();
    rd_exp_q.push_back(e);
    rd_name_q.push_back(nm);
    rd_vld = 1'b1;
    tick();
    rd_vld = 1'b0;
  endtask

  // n pulses, 2 cycles high, period 10
  task automatic pwm_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      repeat (2) tick();
      pwm_in = 1'b0;
      repeat (8) tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded 100000 time units, required to finish");
    $fatal(1);
  end

  initial begin
    int base;
    repeat (2) tick();
    chk("rst_pulse_out", pulse_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data_out", data_out, 0);
    res_n = 1'b1;
    tick();

    // LEN=3 burst
    wr(8'h52, 8'd3);
    wr(8'h50, 8'h01);
    chk("t1_busy", busy, 1);
    tick();
    base = pulses_seen;
    repeat (3) exp_w_q.push_back(2);
    pwm_pulses(3);
    chk("t1_done", done, 1);
    chk("t1_busy_end", busy, 0);
    pwm_pulses(1);
    chk("t1_npulses", pulses_seen - base, 3);
    rd(8'h51, 8'h02, "t1_status");
    rd(8'h56, 8'h03, "t1_sent");
    rd(8'h10, 8'h03, "t1_out_of_window");
    rd(8'h52, 8'h03, "t1_len");

    // START mid-pulse, LEN=1
    wr(8'h52, 8'd1);
    base = pulses_seen;
    pwm_in = 1'b1;
    tick();
    wr(8'h50, 8'h01);
    chk("t2_busy", busy, 1);
    chk("t2_done_clr", done, 0);
    tick();
    pwm_in = 1'b0;
    repeat (3) tick();
    exp_w_q.push_back(2);
    pwm_pulses(2);
    chk("t2_npulses", pulses_seen - base, 1);
    chk("t2_done", done, 1);
    rd(8'h56, 8'h01, "t2_sent");

    // LEN=0
    wr(8'h52, 8'd0);
    base = pulses_seen;
    wr(8'h50, 8'h01);
    chk("t3_busy", busy, 0);
    chk("t3_done_clr", done, 0);
    tick();
    chk("t3_done", done, 1);
    pwm_pulses(1);
    chk("t3_npulses", pulses_seen - base, 0);
    rd(8'h56, 8'h00, "t3_sent");

    // Continuous, abort mid 6th pulse
    wr(8'h50, 8'h05);
    chk("t4_busy", busy, 1);
    tick();
    rd(8'h50, 8'h04, "t4_ctrl_cont");
    base = pulses_seen;
    repeat (5) exp_w_q.push_back(2);
    pwm_pulses(5);
    exp_w_q.push_back(1);
    pwm_in = 1'b1;
    tick();
    chk("t4_pulse_hi", pulse_out, 1);
    wr(8'h50, 8'h02);
    chk("t4_pulse_drop", pulse_out, 0);
    chk("t4_busy_abort", busy, 0);
    chk("t4_done_abort", done, 0);
    pwm_in = 1'b0;
    repeat (3) tick();
    chk("t4_npulses", pulses_seen - base, 6);
    rd(8'h56, 8'h05, "t4_sent0");
    rd(8'h57, 8'h00, "t4_sent1");

    // LEN=4, LEN rewrite and trig while busy
    wr(8'h52, 8'd4);
    wr(8'h50, 8'h01);
    tick();
    base = pulses_seen;
    repeat (4) exp_w_q.push_back(2);
    pwm_pulses(1);
    wr(8'h52, 8'd1);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("t5_busy_trig", busy, 1);
    pwm_pulses(3);
    chk("t5_npulses", pulses_seen - base, 4);
    chk("t5_done", done, 1);
    rd(8'h56, 8'h04, "t5_sent");
    rd(8'h52, 8'h01, "t5_len");
    base = pulses_seen;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    chk("t5_trig_busy", busy, 1);
    chk("t5_trig_done_clr", done, 0);
    tick();
    exp_w_q.push_back(2);
    pwm_pulses(2);
    chk("t5_npulses2", pulses_seen - base, 1);
    chk("t5_done2", done, 1);
    rd(8'h56, 8'h01, "t5_sent2");

    // Async reset during RUN
    wr(8'h52, 8'd5);
    wr(8'h50, 8'h01);
    tick();
    pwm_in = 1'b1;
    tick();
    chk("t6_running", pulse_out, 1);
    #2;
    res_n = 1'b0;
    #1;
    chk("t6_rst_pulse_out", pulse_out, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_data_out", data_out, 0);
    pwm_in = 1'b0;
    repeat (2) tick();
    res_n = 1'b1;
    tick();
    rd(8'h52, 8'h00, "t6_len");
    rd(8'h56, 8'h00, "t6_sent");
    rd(8'h51, 8'h00, "t6_status");

    chk("leftover_pulses", exp_w_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_burst.md
Name: pwm_burst

Overview:
- Downstream stage of the LED PWM generator: consumes its `out` waveform and forwards it to the LED driver.
- Gates the waveform so that exactly N complete pulses pass per trigger (single burst), or all pulses pass until aborted (continuous).
- Configured and monitored over the shared 8-bit addr/data register bus at addresses 0x50–0x59.
- Provides the pulse count for each PMT scan point.

Parameters:
- ADDR_BASE, 8'h50, base address of the register window (10 bytes).
- CNT_W, 32, width of burst length and sent-pulse counter.

Ports:
- clk  in  1  system clock
- res_n  in  1  asynchronous active-low reset
- addr  in  8  register bus address
- data_in  in  8  register write data
- we  in  1  register write strobe, one byte per cycle
- data_out  out  8  register read data, registered
- pwm_in  in  1  waveform from PWM generator, same clock domain
- trig  in  1  external start strobe, level, edge-detected internally
- pulse_out  out  1  gated waveform to LED driver, registered
- busy  out  1  high in ARM or RUN
- done  out  1  sticky burst-complete flag

Behaviour:
- Reset (res_n low, async):
  - state=IDLE.
  - pulse_out=0, busy=0, done=0, data_out=0.
  - All registers=0; sent=0; pwm_d=0; trig_d=0.
- Register map (offsets from ADDR_BASE):
  - +0 CTRL: W1 self-clearing bits. bit0 START, bit1 ABORT, bit2 CONT (sticky mode bit, readable).
  - +1 STATUS (RO): {5'b0, ovf, done, busy}.
  - +2..+5 LEN: 32-bit little-endian burst length, R/W.
  - +6..+9 SENT (RO): 32-bit little-endian sent-pulse count.
- Register access:
  - data_out updates 1 cycle after addr.
  - Addresses outside the window leave data_out unchanged.
  - Writes to RO offsets are ignored.
- Start events: CTRL.START written, or a trig rising edge (trig & ~trig_d).
- Edge detect: rise = pwm_in & ~pwm_d; fall = ~pwm_in & pwm_d.
- FSM:
  - IDLE:
    - On start: latch LEN into len_q, set sent=0, clear done and ovf.
    - If len_q==0 and CONT==0, go to DONE in the same cycle. No pulses are emitted.
    - Otherwise go to ARM.
  - ARM:
    - Wait while pwm_in==1, so a partial leading pulse is never forwarded.
    - When pwm_in==0, go to RUN.
  - RUN:
    - pulse_out <= pwm_in & gate, where gate opens on rise only if CONT or sent<len_q.
    - gate closes on fall. On that fall, sent increments.
    - When sent+1==len_q and CONT==0, go to DONE.
    - Latency pwm_in -> pulse_out is exactly 1 cycle. Pulse width is preserved.
  - DONE: set done=1, pulse_out=0, then go to IDLE the next cycle. done stays set until the next start.
- ABORT: from any state, next state is IDLE and pulse_out=0 next cycle. A truncated final pulse is allowed and is not counted. done stays 0.
- Start while busy is ignored. LEN writes while busy affect only the next burst (len_q is held).
- Simultaneous START and ABORT: ABORT wins.
- SENT saturates at 2^32-1 in CONT mode; ovf is set on saturation.
- busy = (state==ARM || state==RUN), registered.

Decomposition:
- Package pwm_burst_pkg:
  - state enum {IDLE, ARM, RUN, DONE}.
  - Register offset localparams, CTRL bit indices, CNT_W default.
- One sub-module pwm_burst_edge: registered delay and rise/fall strobes. Instantiated twice, for pwm_in and for trig.
- Everything else stays in the top.

Test Plan:
- LEN=3, START while pwm_in idle low, pwm_in period 10 cycles with 2 cycles high:
  - exactly 3 pulse_out pulses, each 2 cycles wide, 1-cycle delayed.
  - done=1 after the 3rd falling edge; SENT reads 3.
- START asserted mid-pulse (pwm_in=1):
  - ARM waits; the first forwarded pulse is the next full one; LEN=1 gives 1 pulse.
- LEN=0, START:
  - done=1 within 2 cycles, no pulse_out activity, SENT=0.
- CONT=1, START, 5 pwm pulses, ABORT written mid-6th pulse:
  - pulse_out drops next cycle, SENT=5, busy=0, done=0.
- Burst of LEN=4, write LEN=1 while busy, trig edge during burst:
  - burst still emits 4 pulses, trig is ignored.
  - the next start emits 1 pulse.
- res_n low during RUN with pulse_out=1:
  - pulse_out, busy, done and all registers read 0 immediately (async).
  - after release, reading +2 returns 0.
